// File: rtl/seq_pkg.sv
// Shared types and default sizing for the serial pattern detector.
// Imported by the stream controller and its pattern matcher.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_DW   = 8;
    localparam int DEF_PW   = 4;
    localparam int DEF_CNTW = 8;

    localparam logic [DEF_PW-1:0] DEF_PATTERN = 4'b0110;

endpackage

// File: rtl/seq_pattern_match.sv
// Serial pattern matcher: bit history, fill count and a registered
// one-cycle match pulse. History spans words and idle gaps.
module seq_pattern_match
    import seq_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          bit_in,
    input  logic          vld,
    input  logic [PW-1:0] pattern,
    input  logic          overlap,
    output logic          match
);

    localparam int FW = $clog2(PW + 1);

    logic [PW-2:0] hist;
    logic [FW-1:0] fill;
    logic [PW-1:0] win;
    logic          hit;

    // Window is the stored history plus the bit on the wire this cycle
    always_comb begin
        win = {hist, bit_in};
        hit = vld && (win == pattern) && (fill >= FW'(PW - 1));
    end

    // History/fill update and registered match pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (clr) begin
                hist <= '0;
                fill <= '0;
            end else if (vld) begin
                hist <= win[PW-2:0];
                if (hit && !overlap) begin
                    fill <= '0;
                end else if (fill != FW'(PW)) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Word-to-bit serialiser feeding the pattern matcher, with a
// saturating match counter and sticky threshold interrupt.
module seq_stream_ctrl
    import seq_pkg::*;
#(
    parameter int              DW          = DEF_DW,
    parameter int              PW          = DEF_PW,
    parameter int              CNTW        = DEF_CNTW,
    parameter logic [PW-1:0]   RST_PATTERN = DEF_PATTERN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [PW-1:0]   cfg_pattern,
    input  logic [CNTW-1:0] cfg_thresh,
    input  logic            cfg_overlap,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic            bit_out,
    output logic            bit_vld,
    output logic            match,
    output logic [CNTW-1:0] match_cnt,
    output logic            irq,
    input  logic            irq_clr,
    output logic            busy
);

    localparam int IW = (DW > 1) ? $clog2(DW) : 1;

    state_t          state;
    logic [DW-1:0]   shreg;
    logic [IW-1:0]   bit_idx;
    logic [PW-1:0]   pattern;
    logic [CNTW-1:0] thresh;
    logic            overlap;
    logic            last;
    logic            accept;
    logic            cfg_ld;
    logic            cnt_clr;
    logic [CNTW-1:0] cnt_nxt;
    logic            irq_nxt;

    // Handshake and config qualifiers depend on state only
    always_comb begin
        last     = (bit_idx == IW'(DW - 1));
        in_ready = (state == IDLE) || ((state == SHIFT) && last);
        accept   = in_valid && in_ready;
        cfg_ld   = cfg_we && (state == IDLE);
        cnt_clr  = irq_clr || cfg_ld;
        busy     = (state == SHIFT);
    end

    // Serialiser FSM: load on accept, shift MSB-first for DW cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            bit_out <= 1'b0;
            bit_vld <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            shreg   <= {in_data[DW-2:0], 1'b0};
            bit_out <= in_data[DW-1];
            bit_vld <= 1'b1;
            bit_idx <= '0;
        end else if ((state == SHIFT) && !last) begin
            shreg   <= {shreg[DW-2:0], 1'b0};
            bit_out <= shreg[DW-1];
            bit_idx <= bit_idx + 1'b1;
        end else if (state == SHIFT) begin
            state   <= IDLE;
            bit_out <= 1'b0;
            bit_vld <= 1'b0;
            bit_idx <= '0;
        end
    end

    // Configuration registers, writable only while idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            pattern <= RST_PATTERN;
            thresh  <= '0;
            overlap <= 1'b1;
        end else if (cfg_ld) begin
            pattern <= cfg_pattern;
            thresh  <= cfg_thresh;
            overlap <= cfg_overlap;
        end
    end

    seq_pattern_match #(
        .PW (PW)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .clr     (cfg_ld),
        .bit_in  (bit_out),
        .vld     (bit_vld),
        .pattern (pattern),
        .overlap (overlap),
        .match   (match)
    );

    // Clear first, then count a coincident match pulse
    always_comb begin
        cnt_nxt = cnt_clr ? '0 : match_cnt;
        irq_nxt = cnt_clr ? 1'b0 : irq;
        if (match && (cnt_nxt != '1)) begin
            cnt_nxt = cnt_nxt + 1'b1;
            if ((thresh != '0) && (cnt_nxt == thresh)) begin
                irq_nxt = 1'b1;
            end
        end
    end

    // Saturating match counter and sticky interrupt
    always_ff @(posedge clk) begin
        if (!reset) begin
            match_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            match_cnt <= cnt_nxt;
            irq       <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Self-checking bench for seq_stream_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_seq_stream_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_pattern = 4'b0;
    logic [7:0] cfg_thresh = 8'h0;
    logic       cfg_overlap = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h0;
    logic       irq_clr = 1'b0;
    logic       in_ready;
    logic       bit_out;
    logic       bit_vld;
    logic       match;
    logic [7:0] match_cnt;
    logic       irq;
    logic       busy;

    int total = 0;
    int bad = 0;

    // reference model state
    bit         mq[$];
    bit         hq[$];
    int         mcnt;
    int         mthr;
    bit         mirq;
    bit         mmatch;
    bit         movl;
    logic [3:0] mpat;

    seq_stream_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_thresh  (cfg_thresh),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .bit_out     (bit_out),
        .bit_vld     (bit_vld),
        .match       (match),
        .match_cnt   (match_cnt),
        .irq         (irq),
        .irq_clr     (irq_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // Advance the model by one edge from the current inputs, then the DUT
    task automatic tick();
        bit         shown = (mq.size() > 0);
        bit         b = shown ? mq[0] : 1'b0;
        bit         idle = (mq.size() == 0);
        bit         rdy = (mq.size() <= 1);
        bit         hit = 1'b0;
        logic [3:0] w;
        if (!reset) begin
            mq.delete();
            hq.delete();
            mcnt = 0;
            mirq = 0;
            mmatch = 0;
            mpat = 4'b0110;
            mthr = 0;
            movl = 1;
        end else begin
            if (shown && hq.size() >= 3) begin
                w = {hq[hq.size()-3], hq[hq.size()-2], hq[hq.size()-1], b};
                hit = (w == mpat);
            end
            if (irq_clr || (cfg_we && idle)) begin
                mcnt = 0;
                mirq = 0;
            end
            if (mmatch && mcnt < 255) begin
                mcnt++;
                if (mthr != 0 && mcnt == mthr) mirq = 1;
            end
            if (shown) begin
                hq.push_back(b);
                if (hq.size() > 8) void'(hq.pop_front());
                if (hit && !movl) hq.delete();
            end
            mmatch = hit;
            if (cfg_we && idle) begin
                mpat = cfg_pattern;
                mthr = int'(cfg_thresh);
                movl = cfg_overlap;
                hq.delete();
            end
            if (shown) void'(mq.pop_front());
            if (in_valid && rdy) begin
                for (int i = 7; i >= 0; i--) mq.push_back(in_data[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        total++;
        if (match_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_cnt got=%0d exp=0", match_cnt);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        total++;
        if (bit_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_vld got=%b exp=0", bit_vld);
        end
        reset = 1'b1;
    endtask

    task automatic test_default_pattern();
        logic [7:0] w = 8'h36;
        bit ev, eb, em;
        send(w);
        for (int k = 1; k <= 10; k++) begin
            ev = (k <= 8);
            eb = ev ? w[8-k] : 1'b0;
            em = (k == 6) || (k == 9);
            total++;
            if (bit_vld !== ev || (ev && bit_out !== eb)) begin
                bad++;
                $display("FAIL dflt_bit k=%0d got=%b/%b exp=%b/%b", k, bit_vld, bit_out, ev, eb);
            end
            total++;
            if (match !== em) begin
                bad++;
                $display("FAIL dflt_match k=%0d got=%b exp=%b", k, match, em);
            end
            tick();
        end
        total++;
        if (match_cnt !== 8'd2) begin
            bad++;
            $display("FAIL dflt_cnt got=%0d exp=2", match_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        cfg_we = 1'b1;
        cfg_pattern = 4'b0110;
        cfg_thresh = 8'd0;
        cfg_overlap = 1'b0;
        send(8'h36);
        cfg_we = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            total++;
            if (match !== (k == 6)) begin
                bad++;
                $display("FAIL novl_match k=%0d got=%b exp=%b", k, match, (k == 6));
            end
            tick();
        end
        total++;
        if (match_cnt !== 8'd1) begin
            bad++;
            $display("FAIL novl_cnt got=%0d exp=1", match_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int run = 0;
        int best = 0;
        bit ev, eb;
        in_valid = 1'b1;
        in_data = 8'hFF;
        for (int c = 0; c < 22; c++) begin
            ev = (mq.size() > 0);
            eb = ev ? mq[0] : 1'b0;
            total++;
            if (in_ready !== (mq.size() <= 1)) begin
                bad++;
                $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, in_ready, (mq.size() <= 1));
            end
            total++;
            if (bit_vld !== ev || (ev && bit_out !== eb)) begin
                bad++;
                $display("FAIL b2b_bit c=%0d got=%b/%b exp=%b/%b", c, bit_vld, bit_out, ev, eb);
            end
            run = bit_vld ? run + 1 : 0;
            if (run > best) best = run;
            if (in_valid && mq.size() <= 1) acc++;
            tick();
            if (acc == 1) in_data = 8'h00;
            if (acc == 2) in_valid = 1'b0;
        end
        total++;
        if (best != 16) begin
            bad++;
            $display("FAIL b2b_run got=%0d exp=16", best);
        end
    endtask

    task automatic test_irq();
        cfg_we = 1'b1;
        cfg_pattern = 4'b0110;
        cfg_thresh = 8'd2;
        cfg_overlap = 1'b1;
        tick();
        cfg_we = 1'b0;
        send(8'h36);
        for (int k = 1; k <= 12; k++) begin
            total++;
            if (irq !== (k >= 10)) begin
                bad++;
                $display("FAIL irq_rise k=%0d got=%b exp=%b", k, irq, (k >= 10));
            end
            tick();
        end
        send(8'h36);
        for (int k = 1; k <= 10; k++) begin
            if (k == 7) begin
                total++;
                if (match_cnt !== 8'd1 || irq !== 1'b0) begin
                    bad++;
                    $display("FAIL irq_coinc got=%0d/%b exp=1/0", match_cnt, irq);
                end
            end
            if (k == 10) begin
                total++;
                if (match_cnt !== 8'd2 || irq !== 1'b1) begin
                    bad++;
                    $display("FAIL irq_again got=%0d/%b exp=2/1", match_cnt, irq);
                end
            end
            irq_clr = (k == 6);
            tick();
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        total++;
        if (match_cnt !== 8'd0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clr got=%0d/%b exp=0/0", match_cnt, irq);
        end
    endtask

    task automatic test_reset_mid();
        send(8'h6F);
        for (int k = 1; k <= 3; k++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++;
        if (bit_vld !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || match !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=vld%b busy%b rdy%b m%b exp=0/0/1/0", bit_vld, busy, in_ready, match);
        end
        send(8'h00);
        for (int k = 1; k <= 10; k++) begin
            total++;
            if (match !== 1'b0) begin
                bad++;
                $display("FAIL mid_stale k=%0d got=%b exp=0", k, match);
            end
            tick();
        end
        send(8'h36);
        for (int k = 1; k <= 11; k++) begin
            total++;
            if (match !== ((k == 6) || (k == 9))) begin
                bad++;
                $display("FAIL cfg_busy k=%0d got=%b exp=%b", k, match, ((k == 6) || (k == 9)));
            end
            if (k == 2) begin
                cfg_we = 1'b1;
                cfg_pattern = 4'b0000;
                cfg_thresh = 8'd1;
                cfg_overlap = 1'b0;
            end
            tick();
            cfg_we = 1'b0;
        end
        total++;
        if (match_cnt !== 8'd2 || irq !== 1'b0) begin
            bad++;
            $display("FAIL cfg_busy_cnt got=%0d/%b exp=2/0", match_cnt, irq);
        end
    endtask

    task automatic test_random();
        bit ev, eb;
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            irq_clr = ($urandom_range(0, 40) == 0);
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_pattern = 4'($urandom);
            cfg_thresh = 8'($urandom_range(0, 5));
            cfg_overlap = 1'($urandom);
            reset = ($urandom_range(0, 300) != 0);
            tick();
            ev = (mq.size() > 0);
            eb = ev ? mq[0] : 1'b0;
            total++;
            if (in_ready !== (mq.size() <= 1) || busy !== ev) begin
                bad++;
                $display("FAIL rnd_ctl c=%0d got=%b/%b exp=%b/%b", c, in_ready, busy, (mq.size() <= 1), ev);
            end
            total++;
            if (bit_vld !== ev || (ev && bit_out !== eb)) begin
                bad++;
                $display("FAIL rnd_bit c=%0d got=%b/%b exp=%b/%b", c, bit_vld, bit_out, ev, eb);
            end
            total++;
            if (match !== mmatch) begin
                bad++;
                $display("FAIL rnd_match c=%0d got=%b exp=%b", c, match, mmatch);
            end
            total++;
            if (match_cnt !== 8'(mcnt) || irq !== mirq) begin
                bad++;
                $display("FAIL rnd_cnt c=%0d got=%0d/%b exp=%0d/%b", c, match_cnt, irq, mcnt, mirq);
            end
        end
        in_valid = 1'b0;
        irq_clr = 1'b0;
        cfg_we = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_default_pattern();
        test_nonoverlap();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
